// File: rtl/pit_fib_requester.sv
// PIT-side initiator for the PIT<->FIB link: forwards one interest and buffers the FIB reply.
// Optional WAIT_FIB timeout is compiled in with `define PIT_FIB_TIMEOUT_EN.
module pit_fib_requester #(
    parameter int MAX_BYTES      = 63,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_prefix,
    input  logic [5:0]  req_len,
    output logic        req_ready,
    output logic [63:0] pit_in_prefix,
    output logic [5:0]  pit_in_len,
    output logic        start_send_to_pit,
    output logic        fib_out_bit,
    input  logic        rejected,
    input  logic        prefix_ready,
    input  logic [63:0] pit_out_prefix,
    input  logic [5:0]  pit_out_len,
    input  logic [7:0]  out_data,
    output logic        rsp_valid,
    input  logic        rsp_ack,
    output logic [1:0]  rsp_status,
    output logic [63:0] rsp_prefix,
    output logic [5:0]  rsp_len,
    input  logic [5:0]  rsp_rd_addr,
    output logic [7:0]  rsp_rd_data
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_FIB, RECV, DONE} state_t;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_REJECTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_TRUNCATED = 2'b11;

    localparam logic [5:0] MAX_LEN    = 6'(MAX_BYTES);
    localparam int         TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
`ifdef PIT_FIB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t               state;
    logic [5:0]           cnt;
    logic [5:0]           last_idx;
    logic [TIMER_W-1:0]   timer;
    logic [7:0]           buffer [0:63];

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            start_send_to_pit <= 1'b0;
            fib_out_bit       <= 1'b0;
            rsp_valid         <= 1'b0;
            pit_in_prefix     <= '0;
            pit_in_len        <= '0;
            rsp_prefix        <= '0;
            rsp_len           <= '0;
            rsp_status        <= ST_OK;
            cnt               <= '0;
            last_idx          <= '0;
            timer             <= '0;
        end else begin
            start_send_to_pit <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pit_in_prefix     <= req_prefix;
                        pit_in_len        <= req_len;
                        req_ready         <= 1'b0;
                        start_send_to_pit <= 1'b1;
                        fib_out_bit       <= 1'b1;
                        state             <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_FIB;
                end
                WAIT_FIB: begin
                    // A rejection outranks a simultaneous prefix_ready; any reply outranks expiry.
                    if (rejected) begin
                        rsp_status  <= ST_REJECTED;
                        rsp_len     <= '0;
                        fib_out_bit <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (prefix_ready) begin
                        rsp_prefix <= pit_out_prefix;
                        rsp_len    <= (pit_out_len > MAX_LEN) ? MAX_LEN : pit_out_len;
                        rsp_status <= (pit_out_len > MAX_LEN) ? ST_TRUNCATED : ST_OK;
                        cnt        <= '0;
                        last_idx   <= pit_out_len - 6'd1;
                        if (pit_out_len == 6'd0) begin
                            fib_out_bit <= 1'b0;
                            rsp_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RECV;
                        end
                    end else if (TIMEOUT_EN && timer == TIMER_LAST) begin
                        rsp_status  <= ST_TIMEOUT;
                        rsp_len     <= '0;
                        fib_out_bit <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RECV: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == last_idx) begin
                        fib_out_bit <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ack) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: payload storage has no reset; contents are only meaningful below rsp_len.
    always_ff @(posedge clk) begin
        if (!rst && state == RECV && cnt < MAX_LEN) begin
            buffer[cnt] <= out_data;
        end
    end

    always_comb begin
        rsp_rd_data = 8'h00;
        if (rsp_rd_addr < rsp_len) begin
            rsp_rd_data = buffer[rsp_rd_addr];
        end
    end

endmodule

// File: tb/tb_pit_fib_requester.sv
// Scoreboard bench for pit_fib_requester (MAX_BYTES=8, TIMEOUT_CYCLES=16).
// Expectation for the silent-FIB case follows PIT_FIB_TIMEOUT_EN.
module tb_pit_fib_requester;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_prefix = '0;
    logic [5:0]  req_len = '0;
    logic        req_ready;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        start_send_to_pit;
    logic        fib_out_bit;
    logic        rejected = 1'b0;
    logic        prefix_ready = 1'b0;
    logic [63:0] pit_out_prefix = '0;
    logic [5:0]  pit_out_len = '0;
    logic [7:0]  out_data = '0;
    logic        rsp_valid;
    logic        rsp_ack = 1'b0;
    logic [1:0]  rsp_status;
    logic [63:0] rsp_prefix;
    logic [5:0]  rsp_len;
    logic [5:0]  rsp_rd_addr = '0;
    logic [7:0]  rsp_rd_data;

    pit_fib_requester #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_prefix(req_prefix), .req_len(req_len), .req_ready(req_ready),
        .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len),
        .start_send_to_pit(start_send_to_pit), .fib_out_bit(fib_out_bit),
        .rejected(rejected), .prefix_ready(prefix_ready),
        .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len), .out_data(out_data),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_status(rsp_status),
        .rsp_prefix(rsp_prefix), .rsp_len(rsp_len),
        .rsp_rd_addr(rsp_rd_addr), .rsp_rd_data(rsp_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [1:0]       status;
        logic [5:0]       len;
        logic [63:0]      prefix;
        bit               chk_prefix;
        logic [7:0][7:0]  data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mon_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rsp_valid rising, including a payload readback.
    initial begin
        bit seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && !seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_latency", 64'(cyc), 64'(e.cyc));
                    check("rsp_status", 64'(rsp_status), 64'(e.status));
                    check("rsp_len", 64'(rsp_len), 64'(e.len));
                    if (e.chk_prefix) check("rsp_prefix", rsp_prefix, e.prefix);
                    for (int k = 0; k < int'(e.len); k++) begin
                        rsp_rd_addr = 6'(k);
                        #1 check($sformatf("rd_data[%0d]", k), 64'(rsp_rd_data), 64'(e.data[k]));
                    end
                    rsp_rd_addr = e.len;
                    #1 check("rd_data_beyond_len", 64'(rsp_rd_data), 64'd0);
                    rsp_rd_addr = '0;
                end
                mon_done++;
            end
            if (!rsp_valid) seen = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends in the first WAIT_FIB cycle.
    task automatic issue_req(input logic [63:0] p, input logic [5:0] l);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_prefix = p; req_len = l;
        tick();
        req_valid = 1'b0; req_prefix = '0; req_len = '0;
        check("send_strobe", 64'(start_send_to_pit), 64'd1);
        check("send_fib_out_bit", 64'(fib_out_bit), 64'd1);
        check("send_req_ready", 64'(req_ready), 64'd0);
        check("pit_in_prefix", pit_in_prefix, p);
        check("pit_in_len", 64'(pit_in_len), 64'(l));
        tick();
        check("strobe_one_cycle", 64'(start_send_to_pit), 64'd0);
        check("wait_fib_out_bit", 64'(fib_out_bit), 64'd1);
        check("pit_in_prefix_held", pit_in_prefix, p);
        check("pit_in_len_held", 64'(pit_in_len), 64'(l));
    endtask

    task automatic wait_mon(input int target);
        int n = 0;
        while (mon_done < target && n < 60) begin tick(); n++; end
        check("monitor_saw_rsp", 64'(mon_done), 64'(target));
    endtask

    task automatic fib_reply(input logic [63:0] p, input logic [5:0] l, input logic [7:0] first);
        exp_t e;
        int stored = (int'(l) > MAXB) ? MAXB : int'(l);
        e.status = (int'(l) > MAXB) ? 2'b11 : 2'b00;
        e.len = 6'(stored);
        e.prefix = p;
        e.chk_prefix = 1;
        e.data = '0;
        for (int k = 0; k < stored; k++) e.data[k] = first + 8'(k);
        e.cyc = cyc + int'(l) + 1;
        sb.push_back(e);
        prefix_ready = 1'b1; pit_out_prefix = p; pit_out_len = l;
        tick();
        prefix_ready = 1'b0;
        for (int k = 0; k < int'(l); k++) begin
            out_data = first + 8'(k);
            tick();
        end
        out_data = 8'hEE;
    endtask

    task automatic do_ack();
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("ack_rsp_valid_low", 64'(rsp_valid), 64'd0);
        check("ack_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        exp_t e;
        int   done_target = 0;

        // Reset
        repeat (5) tick();
        rst = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_strobe", 64'(start_send_to_pit), 64'd0);
        check("rst_fib_out_bit", 64'(fib_out_bit), 64'd0);
        check("rst_pit_in_prefix", pit_in_prefix, 64'd0);
        check("rst_rsp_len", 64'(rsp_len), 64'd0);

        // Normal 4-byte reply
        issue_req(64'hDEAD_BEEF_0000_0001, 6'd32);
        fib_reply(64'h1111_2222_3333_4444, 6'd4, 8'hA1);
        done_target++; wait_mon(done_target);
        do_ack();

        // Rejected together with prefix_ready
        issue_req(64'h0000_0000_0000_00AB, 6'd8);
        e.status = 2'b01; e.len = 6'd0; e.prefix = '0; e.chk_prefix = 0; e.data = '0;
        e.cyc = cyc + 1;
        sb.push_back(e);
        rejected = 1'b1; prefix_ready = 1'b1; pit_out_len = 6'd5; pit_out_prefix = 64'h5;
        tick();
        rejected = 1'b0; prefix_ready = 1'b0;
        check("reject_fib_out_bit", 64'(fib_out_bit), 64'd0);
        done_target++; wait_mon(done_target);
        do_ack();

        // Zero-length reply
        issue_req(64'h0000_0000_0000_0C0C, 6'd3);
        fib_reply(64'hCAFE_0000_0000_0000, 6'd0, 8'h00);
        done_target++; wait_mon(done_target);
        do_ack();

        // Truncation, then ack held off for 20 cycles
        issue_req(64'h0123_4567_89AB_CDEF, 6'd16);
        fib_reply(64'hFEED_FACE_0000_0012, 6'd12, 8'h00);
        done_target++; wait_mon(done_target);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) begin
                check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
                check("hold_req_ready", 64'(req_ready), 64'd0);
                check("hold_status", 64'(rsp_status), 64'd3);
                check("hold_len", 64'(rsp_len), 64'd8);
                check("hold_prefix", rsp_prefix, 64'hFEED_FACE_0000_0012);
            end
        end
        do_ack();

        // Reset in the middle of RECV
        issue_req(64'h0000_0000_0000_0777, 6'd7);
        prefix_ready = 1'b1; pit_out_prefix = 64'h9999; pit_out_len = 6'd10;
        tick();
        prefix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin out_data = 8'(k); tick(); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_fib_out_bit", 64'(fib_out_bit), 64'd0);
        check("midrst_rsp_len", 64'(rsp_len), 64'd0);
        repeat (20) tick();
        check("midrst_no_rsp_valid", 64'(rsp_valid), 64'd0);

        // Silent FIB
        issue_req(64'h0000_0000_0000_0BAD, 6'd1);
`ifdef PIT_FIB_TIMEOUT_EN
        e.status = 2'b10; e.len = 6'd0; e.prefix = '0; e.chk_prefix = 0; e.data = '0;
        e.cyc = cyc + 16;
        sb.push_back(e);
        done_target++; wait_mon(done_target);
        do_ack();
`else
        repeat (100) tick();
        check("silent_rsp_valid", 64'(rsp_valid), 64'd0);
        check("silent_fib_out_bit", 64'(fib_out_bit), 64'd1);
        check("silent_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("silent_rst_req_ready", 64'(req_ready), 64'd1);
`endif

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
